// File: rtl/sipo_deserializer_if.sv
// Bundle of the serial-in and word-out handshake signals of the deserializer.
// The master side drives the serial stream and consumes words; the slave side
// is the deserializer itself.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             sin_valid;
  logic             sin_data;
  logic             sin_sync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             overrun_clr;
  logic [CW-1:0]    bit_count;

  modport master (
    output sin_valid, sin_data, sin_sync, out_ready, overrun_clr,
    input  out_data, out_valid, overrun, bit_count
  );

  modport slave (
    input  sin_valid, sin_data, sin_sync, out_ready, overrun_clr,
    output out_data, out_valid, overrun, bit_count
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer. Collects a bit-serial stream into
// WIDTH-bit words and offers each completed word through a one-deep holding
// register on a valid/ready port. A completed word that finds the holding
// register occupied and not being consumed is dropped and flagged in a sticky
// overrun bit. The bit counter doubles as the state: 0 is a word boundary.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  sipo_deserializer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg_q,      sreg_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q,   overrun_d;

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] first_s;
  logic             last_bit_s;
  logic             complete_s;
  logic             transfer_s;

  // Shift-register image after accepting the current bit, and the image of a
  // word that starts with the current bit after a resynchronisation.
  always_comb begin
    shifted_s = sreg_q;
    first_s   = {WIDTH{1'b0}};
    if (MSB_FIRST) begin
      shifted_s = {sreg_q[WIDTH-2:0], bus.sin_data};
      first_s   = {{(WIDTH-1){1'b0}}, bus.sin_data};
    end else begin
      shifted_s = {bus.sin_data, sreg_q[WIDTH-1:1]};
      first_s   = {bus.sin_data, {(WIDTH-1){1'b0}}};
    end
  end

  // Next-state logic for the shifter, bit counter, holding register and overrun.
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    last_bit_s  = (cnt_q == CW'(WIDTH - 1));
    // A resync never completes a word, even if it lands on the last bit slot.
    complete_s  = bus.sin_valid && !bus.sin_sync && last_bit_s;
    transfer_s  = out_valid_q && bus.out_ready;

    if (bus.sin_sync) begin
      if (bus.sin_valid) begin
        sreg_d = first_s;
        cnt_d  = CW'(1);
      end else begin
        sreg_d = {WIDTH{1'b0}};
        cnt_d  = {CW{1'b0}};
      end
    end else if (bus.sin_valid) begin
      sreg_d = shifted_s;
      if (last_bit_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
    end

    // Load when the holding register is free or is being emptied this cycle,
    // so back-to-back words stream without a bubble.
    if (complete_s && (!out_valid_q || transfer_s)) begin
      out_data_d  = shifted_s;
      out_valid_d = 1'b1;
    end else if (transfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Setting has priority over a simultaneous clear.
    if (complete_s && out_valid_q && !bus.out_ready) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers with synchronous reset; a pending word is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q      <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.bit_count = cnt_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: a vector table for the MSB-first
// instance plus hand-written gap, bit-order and reset sequences.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v, sv_v, sd_v, ss_v, rdy_v, clr_v;

  sipo_deserializer_if #(.WIDTH(8)) if_m ();
  sipo_deserializer_if #(.WIDTH(8)) if_l ();

  assign if_m.sin_valid   = sv_v;
  assign if_m.sin_data    = sd_v;
  assign if_m.sin_sync    = ss_v;
  assign if_m.out_ready   = rdy_v;
  assign if_m.overrun_clr = clr_v;
  assign if_l.sin_valid   = sv_v;
  assign if_l.sin_data    = sd_v;
  assign if_l.sin_sync    = ss_v;
  assign if_l.out_ready   = rdy_v;
  assign if_l.overrun_clr = clr_v;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst_v), .bus(if_m));
  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst_v), .bus(if_l));

  typedef struct {
    logic       rst, sv, sd, ss, rdy, clr;
    logic       ev;
    logic [7:0] ed;
    logic       chk_d;
    logic       eov;
    logic [2:0] ecnt;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic v, input logic d, input logic s,
                       input logic rd, input logic c);
    @(negedge clk);
    rst_v = r; sv_v = v; sd_v = d; ss_v = s; rdy_v = rd; clr_v = c;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic r, input logic v, input logic d, input logic s,
                      input logic rd, input logic c, input logic ev, input logic [7:0] ed,
                      input logic chk_d, input logic eov, input logic [2:0] ecnt);
    vec_t x;
    x.rst = r; x.sv = v; x.sd = d; x.ss = s; x.rdy = rd; x.clr = c;
    x.ev = ev; x.ed = ed; x.chk_d = chk_d; x.eov = eov; x.ecnt = ecnt;
    tbl.push_back(x);
  endtask

  // Eight consecutive bit rows of word w (MSB sent first). Rows 1..7 expect the
  // held state (hv/hd/hov), the last row expects the final state (fv/fd/fov).
  task automatic push_word(input logic [7:0] w, input logic rdy, input logic rdy_last,
                           input logic hv, input logic [7:0] hd, input logic hov,
                           input logic fv, input logic [7:0] fd, input logic fov);
    for (int i = 0; i < 8; i++) begin
      if (i < 7)
        push(1'b0, 1'b1, w[7-i], 1'b0, rdy, 1'b0, hv, hd, hv, hov, 3'(i + 1));
      else
        push(1'b0, 1'b1, w[7-i], 1'b0, rdy_last, 1'b0, fv, fd, fv, fov, 3'd0);
    end
  endtask

  initial begin
    int gaps[8];
    int pulses;
    logic [7:0] c3;

    rst_v = 1'b1; sv_v = 1'b0; sd_v = 1'b0; ss_v = 1'b0; rdy_v = 1'b0; clr_v = 1'b0;

    // Reset state
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0);
    // A5 streamed with consumer ready: one-cycle valid pulse
    push_word(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    // Overrun: 11 held, 22 dropped, then consume and clear
    push_word(8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0);
    push_word(8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    // Simultaneous consume of 33 and completion of 44
    push_word(8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0);
    push_word(8'h44, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'h44, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    // Three partial bits, then resync carrying a 1 and seven 0s -> 80 only
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3);
    push(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1);
    for (int i = 0; i < 7; i++)
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == 6), 8'h80, (i == 6), 1'b0, 3'((i + 2) % 8));
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    // Resync without a bit returns to the word boundary
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2);
    push(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
    push_word(8'h0F, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0F, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].sv, tbl[k].sd, tbl[k].ss, tbl[k].rdy, tbl[k].clr);
      chk($sformatf("tbl[%0d].valid", k), 32'(if_m.out_valid), 32'(tbl[k].ev));
      chk($sformatf("tbl[%0d].overrun", k), 32'(if_m.overrun), 32'(tbl[k].eov));
      chk($sformatf("tbl[%0d].bit_count", k), 32'(if_m.bit_count), 32'(tbl[k].ecnt));
      if (tbl[k].chk_d)
        chk($sformatf("tbl[%0d].data", k), 32'(if_m.out_data), 32'(tbl[k].ed));
    end

    // Bit order with gaps: 1 then seven 0s, both instances
    gaps[0] = 2; gaps[1] = 0; gaps[2] = 1; gaps[3] = 3;
    gaps[4] = 0; gaps[5] = 1; gaps[6] = 2; gaps[7] = 1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap.lsb_reset_cnt", 32'(if_l.bit_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk($sformatf("gap.hold_cnt_m[%0d]", i), 32'(if_m.bit_count), 32'(i));
        chk($sformatf("gap.hold_cnt_l[%0d]", i), 32'(if_l.bit_count), 32'(i));
      end
      drive(1'b0, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
      chk($sformatf("gap.cnt_m[%0d]", i), 32'(if_m.bit_count), 32'((i + 1) % 8));
      chk($sformatf("gap.cnt_l[%0d]", i), 32'(if_l.bit_count), 32'((i + 1) % 8));
    end
    chk("gap.valid_m", 32'(if_m.out_valid), 32'd1);
    chk("gap.data_m", 32'(if_m.out_data), 32'h80);
    chk("gap.valid_l", 32'(if_l.out_valid), 32'd1);
    chk("gap.data_l", 32'(if_l.out_data), 32'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap.stable_l", 32'(if_l.out_data), 32'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap.consumed_l", 32'(if_l.out_valid), 32'd0);

    // Reset while a word is held and a partial word is in flight
    for (int i = 0; i < 8; i++) begin
      c3 = 8'h5A;
      drive(1'b0, 1'b1, c3[7-i], 1'b0, 1'b0, 1'b0);
    end
    chk("rst.pre_valid", 32'(if_m.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.pre_cnt", 32'(if_m.bit_count), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.valid", 32'(if_m.out_valid), 32'd0);
    chk("rst.data", 32'(if_m.out_data), 32'd0);
    chk("rst.overrun", 32'(if_m.overrun), 32'd0);
    chk("rst.cnt", 32'(if_m.bit_count), 32'd0);
    pulses = 0;
    c3 = 8'hC3;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive(1'b0, 1'b1, c3[7-i], 1'b0, 1'b1, 1'b0);
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (if_m.out_valid === 1'b1) begin
        pulses++;
        chk("rst.word_data", 32'(if_m.out_data), 32'hC3);
      end
    end
    chk("rst.word_count", 32'(pulses), 32'd1);
    chk("rst.no_overrun", 32'(if_m.overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
